// File: rtl/sodor1_pkg.sv
// Shared definitions for the Sodor 1-stage RV32I ISA reference model.
// Holds the opcode and funct3 encodings used by the decoder, the ALU
// operation enum, and the immediate sign-extension helpers.
package sodor1_pkg;

    // Major opcodes handled by the model; everything else executes as a NOP.
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // ALU funct3 encodings (shared by R-type and I-type).
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 encodings; 010 and 011 are unused and never taken.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd
    } alu_op_e;

    function automatic logic [31:0] imm_i_of(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_b_of(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/sodor1_alu.sv
// Combinational RV32I integer ALU.
// Ports:
//   a_i      - first operand (rs1 value)
//   b_i      - second operand (rs2 value or sign-extended immediate)
//   op_i     - operation select
//   result_o - 32-bit result; shifts use b_i[4:0], compares return 0/1
module sodor1_alu
    import sodor1_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] result_o
);

    logic [4:0] shamt;

    always_comb begin
        shamt    = b_i[4:0];
        result_o = '0;
        unique case (op_i)
            AluAdd:  result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluSll:  result_o = a_i << shamt;
            AluSlt:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            AluSltu: result_o = {31'b0, a_i < b_i};
            AluXor:  result_o = a_i ^ b_i;
            AluSrl:  result_o = a_i >> shamt;
            AluSra:  result_o = $unsigned($signed(a_i) >>> shamt);
            AluOr:   result_o = a_i | b_i;
            AluAnd:  result_o = a_i & b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/sodor1_isa_model.sv
// Architectural reference model of the Sodor 1-stage RV32I core, limited to
// R-type ALU, I-type ALU and conditional branches. One instruction commits
// per rising clock edge while reset is low.
// Ports:
//   clk                          - clock, state updates on rising edge
//   reset                        - asynchronous active-high reset
//   fe_in_io_imem_resp_bits_data - instruction word fetched at port_pc
//   port_regfile                 - packed register file, x[i] at [32*i+31:32*i]
//   port_pc                      - address of the instruction being presented
module sodor1_isa_model
    import sodor1_pkg::*;
#(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        fe_in_io_imem_resp_bits_data,
    output logic [32*XLEN-1:0]     port_regfile,
    output logic [XLEN-1:0]        port_pc
);

    logic [XLEN-1:0] pc_q, pc_d;
    // Entry 0 is reset to zero and never written, so reads of x0 return 0.
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];

    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic            alt;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_b;
    logic [XLEN-1:0] alu_b, alu_res;
    alu_op_e         alu_op;
    logic            is_r, is_i, is_br, br_taken, wr_en;

    always_comb begin
        instr   = fe_in_io_imem_resp_bits_data;
        opcode  = instr[6:0];
        rd      = instr[11:7];
        funct3  = instr[14:12];
        rs1     = instr[19:15];
        rs2     = instr[24:20];
        alt     = instr[30];
        imm_i   = imm_i_of(instr);
        imm_b   = imm_b_of(instr);
        rs1_val = rf_q[rs1];
        rs2_val = rf_q[rs2];
        is_r    = (opcode == OP_R);
        is_i    = (opcode == OP_I);
        is_br   = (opcode == OP_BR);
        alu_b   = is_r ? rs2_val : imm_i;
    end

    // funct7[5] / instr[30] picks SUB only for R-type; it picks SRA for both.
    always_comb begin
        alu_op = AluAdd;
        case (funct3)
            F3_ADD:  alu_op = (is_r && alt) ? AluSub : AluAdd;
            F3_SLL:  alu_op = AluSll;
            F3_SLT:  alu_op = AluSlt;
            F3_SLTU: alu_op = AluSltu;
            F3_XOR:  alu_op = AluXor;
            F3_SR:   alu_op = alt ? AluSra : AluSrl;
            F3_OR:   alu_op = AluOr;
            F3_AND:  alu_op = AluAnd;
            default: alu_op = AluAdd;
        endcase
    end

    sodor1_alu u_alu (
        .a_i      (rs1_val),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_res)
    );

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val < rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d  = (is_br && br_taken) ? pc_q + imm_b : pc_q + 32'd4;
        wr_en = (is_r || is_i) && (rd != 5'd0);
        rf_d  = rf_q;
        if (wr_en) begin
            rf_d[rd] = alu_res;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            rf_q <= rf_d;
        end
    end

    always_comb begin
        port_pc = pc_q;
        for (int i = 0; i < 32; i++) begin
            port_regfile[XLEN*i +: XLEN] = rf_q[i];
        end
    end

endmodule

// File: tb/tb_sodor1_isa_model.sv
// Self-checking bench for sodor1_isa_model: directed program plus a random
// instruction stream, compared against an ISA-level model of PC and x0..x31.
module tb_sodor1_isa_model;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic          clk;
    logic          reset;
    logic [31:0]   instr;
    logic [1023:0] port_regfile;
    logic [31:0]   port_pc;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_x [32];
    logic [31:0] m_pc;

    sodor1_isa_model dut (
        .clk                          (clk),
        .reset                        (reset),
        .fe_in_io_imem_resp_bits_data (instr),
        .port_regfile                 (port_regfile),
        .port_pc                      (port_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic is_r, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (f3)
            3'd0: return (is_r && alt) ? a + (~b + 1) : a + b;
            3'd1: return a * (32'd1 << s);
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt && a[31]) return (a >> s) | ~(32'hFFFF_FFFF >> s);
                return a >> s;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
    endtask

    task automatic model_exec(input logic [31:0] ins);
        logic [31:0] a, b, imm, off, res;
        logic        wr, tk;
        a   = m_x[ins[19:15]];
        b   = m_x[ins[24:20]];
        imm = {{20{ins[31]}}, ins[31:20]};
        off = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        wr  = 1'b0;
        res = '0;
        tk  = 1'b0;
        case (ins[6:0])
            7'b0110011: begin res = ref_alu(ins[14:12], ins[30], 1'b1, a, b); wr = 1'b1; end
            7'b0010011: begin res = ref_alu(ins[14:12], ins[30], 1'b0, a, imm); wr = 1'b1; end
            7'b1100011: begin
                case (ins[14:12])
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = !($signed(a) < $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = !(a < b);
                    default: tk = 1'b0;
                endcase
            end
            default: ;
        endcase
        if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = res;
        m_pc = tk ? m_pc + off : m_pc + 32'd4;
    endtask

    function automatic logic [1023:0] model_rf();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = m_x[i];
        return r;
    endfunction

    // ---------------- checkers ----------------
    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic [1023:0] exp);
        n_vec++;
        assert (port_regfile === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, port_regfile, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk32({tag, "_pc"}, port_pc, m_pc);
        chk_rf({tag, "_rf"}, model_rf());
    endtask

    function automatic logic [31:0] xr(input int idx);
        return port_regfile[32*idx +: 32];
    endfunction

    // Present one instruction, let it commit, then sample 1 time unit later.
    task automatic step(input logic [31:0] ins);
        instr = ins;
        @(posedge clk);
        #1;
        model_exec(ins);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] pc_before;
    logic [31:0] rnd;
    logic [12:0] boff;

    initial begin
        reset = 1'b1;
        instr = 32'h0000_0013;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        chk32("pc_after_release", port_pc, 32'h8000_0000);

        // NOPs advance the PC by 4.
        step(32'h0000_0013); chk32("nop1_pc", port_pc, 32'h8000_0004);
        step(32'h0000_0013); chk32("nop2_pc", port_pc, 32'h8000_0008);
        step(32'h0000_0013); chk32("nop3_pc", port_pc, 32'h8000_000C);
        chk_rf("nop_rf_zero", '0);

        step(32'hFFF0_0093);                              chk32("addi_x1", xr(1), 32'hFFFF_FFFF);
        step(enc_i(12'd5, 5'd0, 3'b000, 5'd2));           chk32("addi_x2", xr(2), 32'd5);
        step(enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3));     chk32("sub_x3", xr(3), 32'd6);
        chk_state("after_sub");

        step(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd4));     chk32("slt_x4", xr(4), 32'd1);
        step(enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd5));     chk32("sltu_x5", xr(5), 32'd0);
        step(enc_i(12'h404, 5'd1, 3'b101, 5'd6));         chk32("srai_x6", xr(6), 32'hFFFF_FFFF);
        step(enc_i(12'h004, 5'd1, 3'b101, 5'd7));         chk32("srli_x7", xr(7), 32'h0FFF_FFFF);

        pc_before = port_pc;
        step(enc_b(13'd8, 5'd1, 5'd2, 3'b100));
        chk32("blt_taken", port_pc, pc_before + 32'd8);
        pc_before = port_pc;
        step(enc_b(13'd8, 5'd1, 5'd2, 3'b110));
        chk32("bltu_not_taken", port_pc, pc_before + 32'd4);
        pc_before = port_pc;
        step(enc_b(13'h1FFC, 5'd0, 5'd0, 3'b000));
        chk32("beq_back", port_pc, pc_before - 32'd4);
        chk_state("after_branches");

        step(enc_i(12'd7, 5'd0, 3'b000, 5'd0));           chk32("x0_stays_zero", xr(0), 32'd0);
        pc_before = port_pc;
        step(32'h0000_2083);
        chk32("unsupported_pc", port_pc, pc_before + 32'd4);
        chk32("unsupported_x1", xr(1), 32'hFFFF_FFFF);
        chk_state("after_unsupported");

        // Random instruction stream.
        for (int k = 0; k < 400; k++) begin
            rnd = $urandom;
            case ($urandom_range(0, 4))
                0, 1: step(enc_i(rnd[31:20], rnd[19:15], rnd[14:12], rnd[11:7]));
                2: step(enc_r(rnd[0] ? 7'h20 : 7'h00, rnd[24:20], rnd[19:15], rnd[14:12],
                              rnd[11:7]));
                3: begin
                    boff = rnd[31:19] & 13'h1FFE;
                    step(enc_b(boff, rnd[19:15], rnd[24:20], rnd[14:12]));
                end
                default: step(rnd);
            endcase
            chk_state("random");
        end

        // Asynchronous reset mid-program, away from the clock edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk32("async_rst_pc", port_pc, 32'h8000_0000);
        chk_rf("async_rst_rf", '0);
        instr = enc_i(12'd9, 5'd0, 3'b000, 5'd1);
        @(posedge clk);
        #1;
        chk_state("rst_held");
        @(negedge clk);
        reset = 1'b0;
        step(enc_i(12'd9, 5'd0, 3'b000, 5'd1));
        chk32("resume_pc", port_pc, 32'h8000_0004);
        chk32("resume_x1", xr(1), 32'd9);
        chk_state("resume");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
